scratchpad_banked: RTL and testbench

SCRATCHPAD_BANKED -- requirements
Module: scratchpad_banked

---
 rtl/scratchpad_banked.sv | 176 +++++++++++++++++
 tb/tb_scratchpad_banked.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/scratchpad_banked.sv
// rtl/scratchpad_banked.sv - multi-port banked scratchpad with per-bank round-robin arbitration
module scratchpad_banked #(
    parameter int NPORTS = 4,
    parameter int NBANKS = 4,
    parameter int DEPTH  = 256,
    parameter int RD_LAT = 2
) (
    input  logic                     clk,
    input  logic                     n_rst,
    input  logic [NPORTS-1:0]        rd_valid,
    input  logic [NPORTS-1:0][31:0]  rd_addr,
    output logic [NPORTS-1:0]        rd_ready,
    output logic [NPORTS-1:0]        rd_rvalid,
    output logic [NPORTS-1:0][31:0]  rd_rdata,
    input  logic [NPORTS-1:0]        wr_valid,
    input  logic [NPORTS-1:0][31:0]  wr_addr,
    input  logic [NPORTS-1:0][31:0]  wr_data,
    output logic [NPORTS-1:0]        wr_ready,
    output logic                     err_oob,
    output logic [31:0]              stall_cnt
);

    localparam int BANK_W = (NBANKS > 1) ? $clog2(NBANKS) : 1;
    localparam int ROW_W  = (DEPTH  > 1) ? $clog2(DEPTH)  : 1;
    localparam int PTR_W  = (NPORTS > 1) ? $clog2(NPORTS) : 1;
    localparam logic [32:0] N_WORDS = 33'(NBANKS * DEPTH);

    logic [NPORTS-1:0]              rd_inr, wr_inr;
    logic [NPORTS-1:0][BANK_W-1:0]  rd_bank, wr_bank;
    logic [NPORTS-1:0][ROW_W-1:0]   rd_row, wr_row;

    logic [NBANKS-1:0][NPORTS-1:0]  rd_req_b, wr_req_b, rd_gnt_b, wr_gnt_b;
    logic [NPORTS-1:0]              rd_gnt, wr_gnt;
    logic [NBANKS-1:0][PTR_W-1:0]   rd_ptr, wr_ptr;

    logic [NPORTS-1:0]              rd_acc, wr_acc, wr_commit;
    logic [NPORTS-1:0][31:0]        rd_word;

    logic [31:0]                    mem [NBANKS][DEPTH];
    logic [NBANKS-1:0][DEPTH-1:0]   written;

    logic [NPORTS-1:0]              pipe_v [RD_LAT];
    logic [NPORTS-1:0][31:0]        pipe_d [RD_LAT];

    logic                           oob_evt, stall_evt;

    // First requester at or after ptr wins.
    function automatic logic [NPORTS-1:0] rr_pick(input logic [NPORTS-1:0] req,
                                                  input logic [PTR_W-1:0]  ptr);
        logic [NPORTS-1:0] g;
        int idx;
        g = '0;
        for (int k = 0; k < NPORTS; k++) begin
            idx = (int'(ptr) + k) % NPORTS;
            if (req[idx] && (g == '0))
                g[idx] = 1'b1;
        end
        return g;
    endfunction

    function automatic logic [PTR_W-1:0] rr_next(input logic [NPORTS-1:0] g,
                                                 input logic [PTR_W-1:0]  ptr);
        logic [PTR_W-1:0] n;
        n = ptr;
        for (int i = 0; i < NPORTS; i++)
            if (g[i])
                n = PTR_W'((i + 1) % NPORTS);
        return n;
    endfunction

    always_comb begin
        for (int i = 0; i < NPORTS; i++) begin
            rd_inr[i]  = {1'b0, rd_addr[i]} < N_WORDS;
            wr_inr[i]  = {1'b0, wr_addr[i]} < N_WORDS;
            rd_bank[i] = rd_addr[i][BANK_W-1:0];
            wr_bank[i] = wr_addr[i][BANK_W-1:0];
            rd_row[i]  = rd_addr[i][BANK_W +: ROW_W];
            wr_row[i]  = wr_addr[i][BANK_W +: ROW_W];
        end
    end

    always_comb begin
        rd_gnt = '0;
        wr_gnt = '0;
        for (int b = 0; b < NBANKS; b++) begin
            for (int i = 0; i < NPORTS; i++) begin
                rd_req_b[b][i] = rd_valid[i] && rd_inr[i] && (rd_bank[i] == BANK_W'(b));
                wr_req_b[b][i] = wr_valid[i] && wr_inr[i] && (wr_bank[i] == BANK_W'(b));
            end
            rd_gnt_b[b] = rr_pick(rd_req_b[b], rd_ptr[b]);
            wr_gnt_b[b] = rr_pick(wr_req_b[b], wr_ptr[b]);
            rd_gnt      = rd_gnt | rd_gnt_b[b];
            wr_gnt      = wr_gnt | wr_gnt_b[b];
        end
    end

    // Out-of-range requests bypass the banks and are always taken.
    assign rd_ready  = n_rst ? (rd_gnt | (rd_valid & ~rd_inr)) : '0;
    assign wr_ready  = n_rst ? (wr_gnt | (wr_valid & ~wr_inr)) : '0;
    assign rd_acc    = rd_valid & rd_ready;
    assign wr_acc    = wr_valid & wr_ready;
    assign wr_commit = wr_acc & wr_inr;
    assign oob_evt   = |(rd_acc & ~rd_inr) || |(wr_acc & ~wr_inr);
    assign stall_evt = |(rd_valid & ~rd_ready) || |(wr_valid & ~wr_ready);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            for (int b = 0; b < NBANKS; b++) begin
                rd_ptr[b] <= rr_next(rd_gnt_b[b], rd_ptr[b]);
                wr_ptr[b] <= rr_next(wr_gnt_b[b], wr_ptr[b]);
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NPORTS; i++)
            if (wr_commit[i])
                mem[wr_bank[i]][wr_row[i]] <= wr_data[i];
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            written <= '0;
        end else begin
            for (int i = 0; i < NPORTS; i++)
                if (wr_commit[i])
                    written[wr_bank[i]][wr_row[i]] <= 1'b1;
        end
    end

    // Array is sampled before the same-edge write lands, giving read-before-write.
    always_comb begin
        for (int i = 0; i < NPORTS; i++) begin
            rd_word[i] = '0;
            if (rd_acc[i] && rd_inr[i] && written[rd_bank[i]][rd_row[i]])
                rd_word[i] = mem[rd_bank[i]][rd_row[i]];
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int s = 0; s < RD_LAT; s++) begin
                pipe_v[s] <= '0;
                pipe_d[s] <= '0;
            end
        end else begin
            pipe_v[0] <= rd_acc;
            pipe_d[0] <= rd_word;
            for (int s = 1; s < RD_LAT; s++) begin
                pipe_v[s] <= pipe_v[s-1];
                pipe_d[s] <= pipe_d[s-1];
            end
        end
    end

    always_comb begin
        rd_rvalid = pipe_v[RD_LAT-1];
        for (int i = 0; i < NPORTS; i++)
            rd_rdata[i] = pipe_v[RD_LAT-1][i] ? pipe_d[RD_LAT-1][i] : 32'd0;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            err_oob   <= 1'b0;
            stall_cnt <= '0;
        end else begin
            err_oob <= oob_evt;
            if (stall_evt && (stall_cnt != 32'hFFFF_FFFF))
                stall_cnt <= stall_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_scratchpad_banked.sv
// tb/tb_scratchpad_banked.sv - directed assertion bench for scratchpad_banked
module tb_scratchpad_banked;

    logic             clk = 1'b0;
    logic             n_rst;
    logic [3:0]       rd_valid, rd_ready, rd_rvalid;
    logic [3:0][31:0] rd_addr, rd_rdata;
    logic [3:0]       wr_valid, wr_ready;
    logic [3:0][31:0] wr_addr, wr_data;
    logic             err_oob;
    logic [31:0]      stall_cnt;

    int n_assert = 0;
    int n_fail   = 0;

    scratchpad_banked #(.NPORTS(4), .NBANKS(4), .DEPTH(16), .RD_LAT(2)) dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .rd_valid  (rd_valid),
        .rd_addr   (rd_addr),
        .rd_ready  (rd_ready),
        .rd_rvalid (rd_rvalid),
        .rd_rdata  (rd_rdata),
        .wr_valid  (wr_valid),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_ready  (wr_ready),
        .err_oob   (err_oob),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        n_rst    = 1'b0;
        rd_valid = '0;
        rd_addr  = '0;
        wr_valid = '0;
        wr_addr  = '0;
        wr_data  = '0;
        repeat (2) step();

        // reset state, ready held low
        rd_valid = 4'hF;
        wr_valid = 4'hF;
        #1;
        chk("rst_rd_ready", 32'(rd_ready), 32'h0);
        chk("rst_wr_ready", 32'(wr_ready), 32'h0);
        chk("rst_rvalid", 32'(rd_rvalid), 32'h0);
        chk("rst_err", 32'(err_oob), 32'h0);
        chk("rst_stall", stall_cnt, 32'h0);
        rd_valid = '0;
        wr_valid = '0;
        step();
        n_rst = 1'b1;
        step();

        // write addr 5, read it back on port 1; unwritten addr 6 reads 0
        wr_valid = 4'b0001; wr_addr[0] = 32'd5; wr_data[0] = 32'h3F80_0000;
        #1 chk("t1_wr_ready", 32'(wr_ready), 32'h1);
        step();
        wr_valid = '0;
        rd_valid = 4'b0010; rd_addr[1] = 32'd5;
        #1 chk("t1_rd_ready", 32'(rd_ready), 32'h2);
        step();
        rd_valid = '0;
        chk("t1_rvalid_early", 32'(rd_rvalid), 32'h0);
        step();
        chk("t1_rvalid", 32'(rd_rvalid), 32'h2);
        chk("t1_rdata", rd_rdata[1], 32'h3F80_0000);
        chk("t1_rdata_idle", rd_rdata[0], 32'h0);
        rd_valid = 4'b0010; rd_addr[1] = 32'd6;
        step();
        rd_valid = '0;
        step();
        chk("t1_rvalid6", 32'(rd_rvalid), 32'h2);
        chk("t1_rdata6", rd_rdata[1], 32'h0);
        chk("t1_stall", stall_cnt, 32'h0);

        // four ports contend for bank 0
        rd_valid = 4'hF;
        rd_addr[0] = 32'd0; rd_addr[1] = 32'd4; rd_addr[2] = 32'd8; rd_addr[3] = 32'd12;
        #1 chk("t2_gnt0", 32'(rd_ready), 32'h1);
        step();
        rd_valid = 4'b1110;
        #1 chk("t2_gnt1", 32'(rd_ready), 32'h2);
        step();
        chk("t2_rv0", 32'(rd_rvalid), 32'h1);
        rd_valid = 4'b1100;
        #1 chk("t2_gnt2", 32'(rd_ready), 32'h4);
        step();
        chk("t2_rv1", 32'(rd_rvalid), 32'h2);
        rd_valid = 4'b1000;
        #1 chk("t2_gnt3", 32'(rd_ready), 32'h8);
        step();
        chk("t2_rv2", 32'(rd_rvalid), 32'h4);
        rd_valid = '0;
        chk("t2_stall", stall_cnt, 32'd3);
        step();
        chk("t2_rv3", 32'(rd_rvalid), 32'h8);

        // parallel writes then parallel reads, all distinct banks
        wr_valid = 4'b1110;
        wr_addr[1] = 32'd1; wr_addr[2] = 32'd2; wr_addr[3] = 32'd3;
        wr_data[1] = 32'h11; wr_data[2] = 32'h22; wr_data[3] = 32'h33;
        #1 chk("t3_wr_ready", 32'(wr_ready), 32'hE);
        step();
        wr_valid = '0;
        rd_valid = 4'hF;
        rd_addr[0] = 32'd0; rd_addr[1] = 32'd1; rd_addr[2] = 32'd2; rd_addr[3] = 32'd3;
        #1 chk("t3_rd_ready", 32'(rd_ready), 32'hF);
        step();
        rd_valid = '0;
        step();
        chk("t3_rvalid", 32'(rd_rvalid), 32'hF);
        chk("t3_rdata0", rd_rdata[0], 32'h0);
        chk("t3_rdata1", rd_rdata[1], 32'h11);
        chk("t3_rdata2", rd_rdata[2], 32'h22);
        chk("t3_rdata3", rd_rdata[3], 32'h33);
        chk("t3_stall", stall_cnt, 32'd3);

        // same-cycle read and write of addr 9
        wr_valid = 4'b0100; wr_addr[2] = 32'd9; wr_data[2] = 32'd2;
        step();
        wr_valid = 4'b0001; wr_addr[0] = 32'd9; wr_data[0] = 32'd7;
        rd_valid = 4'b1000; rd_addr[3] = 32'd9;
        #1;
        chk("t4_wr_ready", 32'(wr_ready), 32'h1);
        chk("t4_rd_ready", 32'(rd_ready), 32'h8);
        step();
        wr_valid = '0;
        rd_valid = '0;
        step();
        chk("t4_old", rd_rdata[3], 32'd2);
        rd_valid = 4'b1000;
        step();
        rd_valid = '0;
        step();
        chk("t4_new", rd_rdata[3], 32'd7);

        // out-of-range read and write
        chk("t5_err_idle", 32'(err_oob), 32'h0);
        rd_valid = 4'b0001; rd_addr[0] = 32'd64;
        wr_valid = 4'b0010; wr_addr[1] = 32'd100; wr_data[1] = 32'hDEAD;
        #1;
        chk("t5_rd_ready", 32'(rd_ready), 32'h1);
        chk("t5_wr_ready", 32'(wr_ready), 32'h2);
        step();
        rd_valid = '0;
        wr_valid = '0;
        chk("t5_err_pulse", 32'(err_oob), 32'h1);
        step();
        chk("t5_err_clear", 32'(err_oob), 32'h0);
        chk("t5_rvalid", 32'(rd_rvalid), 32'h1);
        chk("t5_rdata", rd_rdata[0], 32'h0);
        rd_valid = 4'b0011; rd_addr[0] = 32'd36; rd_addr[1] = 32'd1;
        step();
        rd_valid = '0;
        step();
        chk("t5_mem36", rd_rdata[0], 32'h0);
        chk("t5_mem1", rd_rdata[1], 32'h11);

        // reset with two reads in flight
        rd_valid = 4'b0011; rd_addr[0] = 32'd5; rd_addr[1] = 32'd2;
        step();
        rd_valid = '0;
        #1 n_rst = 1'b0;
        #1;
        chk("t6_rvalid_rst", 32'(rd_rvalid), 32'h0);
        rd_valid = 4'b0001;
        #1 chk("t6_ready_rst", 32'(rd_ready), 32'h0);
        rd_valid = '0;
        step();
        chk("t6_rvalid_hold", 32'(rd_rvalid), 32'h0);
        n_rst = 1'b1;
        step();
        chk("t6_rvalid_after", 32'(rd_rvalid), 32'h0);
        chk("t6_stall", stall_cnt, 32'h0);
        rd_valid = 4'b0011;
        step();
        rd_valid = '0;
        step();
        chk("t6_rvalid_rd", 32'(rd_rvalid), 32'h3);
        chk("t6_rdata5", rd_rdata[0], 32'h0);
        chk("t6_rdata2", rd_rdata[1], 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
